mdv_mem_arbiter: RTL and testbench

// - Shares the single SDRAM read port between the MDV1_ and MDV2_ microdrive image readers.
// - Issues at most one read per free (non-video) memory slot and returns each word to the requester that asked for it.
// - Sits between the two mdv instances and the SDRAM controller. Replaces the duplicated mem_addr/mem_read paths.

---
 rtl/mdv_arb_pkg.sv | 17 +
 rtl/mdv_arb_pick.sv | 31 +++
 rtl/mdv_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mdv_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdv_arb_pkg.sv
// Shared types and constants for the microdrive SDRAM read arbiter.
// Consumers: mdv_arb_pick, mdv_mem_arbiter.
package mdv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic CH_MDV1 = 1'b0;
    localparam logic CH_MDV2 = 1'b1;

    localparam int LAT_W = 3;

endpackage

// File: rtl/mdv_arb_pick.sv
// Combinational 2-way winner select for the microdrive arbiter.
// Build option: MDV_ARB_SELPRIO_EN gives the selected drive priority on contention.
module mdv_arb_pick
    import mdv_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    input  logic sel_drive,
    output logic gnt
);

`ifndef MDV_ARB_SELPRIO_EN
    logic unused_sel_drive;
    assign unused_sel_drive = sel_drive;
`endif

    always_comb begin
        gnt = CH_MDV1;
        if (req0 && req1) begin
`ifdef MDV_ARB_SELPRIO_EN
            gnt = sel_drive;
`else
            gnt = ~rr_last;
`endif
        end else if (req1) begin
            gnt = CH_MDV2;
        end
    end

endmodule

// File: rtl/mdv_mem_arbiter.sv
// Shares the SDRAM read port between the MDV1_ and MDV2_ image readers, one read per free slot.
// Build option: MDV_ARB_SELPRIO_EN (see mdv_arb_pick).
module mdv_mem_arbiter
    import mdv_arb_pkg::*;
#(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int DATA_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_ena,
    input  logic              mem_slot,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    input  logic              sel_drive,
    output logic              busy
);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic             gnt;
    logic             pick_gnt;
    logic             rr_last;
    logic             live;
    logic             start;
    logic             req_g;
    logic [LAT_W-1:0] lat_cnt;

    mdv_arb_pick u_pick (
        .req0      (req0),
        .req1      (req1),
        .rr_last   (rr_last),
        .sel_drive (sel_drive),
        .gnt       (pick_gnt)
    );

    assign start = mem_slot && mem_ena && (req0 || req1);
    assign req_g = (gnt == CH_MDV2) ? req1 : req0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Acks are gated by live so a withdrawn request completes silently.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE: begin
                mem_rd    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    if (lat_cnt == '0) state_nxt = RESP;
            RESP: begin
                ack0      = live && (gnt == CH_MDV1);
                ack1      = live && (gnt == CH_MDV2);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= CH_MDV1;
            rr_last  <= CH_MDV2;
            live     <= 1'b0;
            lat_cnt  <= '0;
            mem_addr <= '0;
            data0    <= '0;
            data1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        gnt      <= pick_gnt;
                        mem_addr <= (pick_gnt == CH_MDV2) ? addr1 : addr0;
                        live     <= 1'b1;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_W'(DATA_LAT - 1);
                    live    <= live && req_g;
                end
                WAIT: begin
                    live <= live && req_g;
                    if (lat_cnt == '0) begin
                        if (live && req_g) begin
                            if (gnt == CH_MDV2) data1 <= mem_din;
                            else                data0 <= mem_din;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    rr_last <= gnt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdv_mem_arbiter.sv
// Directed bench for mdv_mem_arbiter: scoreboard queues for issued reads and acks.
// Memory model returns addr[15:0] ^ 16'hBFEF, DATA_LAT cycles after mem_rd.
module tb_mdv_mem_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int DATA_LAT = 2;

  logic              clk;
  logic              reset_n;
  logic              mem_ena;
  logic              mem_slot;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_din;
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              sel_drive;
  logic              busy;

  int total;
  int bad;
  int rd_total;
  int rd_cnt;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W:0]   exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  mdv_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DATA_LAT (DATA_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_ena   (mem_ena),
    .mem_slot  (mem_slot),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_din   (mem_din),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .ack0      (ack0),
    .ack1      (ack1),
    .data0     (data0),
    .data1     (data1),
    .sel_drive (sel_drive),
    .busy      (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slot();
    @(negedge clk);
    mem_slot = 1'b1;
    @(negedge clk);
    mem_slot = 1'b0;
  endtask

  task automatic expect_rd(input logic ch, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit acked);
    addr_q.push_back(a);
    if (acked) exp_q.push_back({ch, d});
  endtask

  // memory model: one word DATA_LAT cycles after mem_rd, garbage otherwise
  initial begin
    rd_cnt   = 0;
    rd_total = 0;
    rd_addr  = '0;
    mem_din  = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (rd_cnt != 0) begin
        rd_cnt--;
        mem_din = (rd_cnt == 0) ? (rd_addr[15:0] ^ 16'hBFEF) : 16'hDEAD;
      end else begin
        mem_din = 16'hDEAD;
      end
      if (mem_rd) begin
        chk("one_outstanding", rd_cnt, 0);
        rd_total++;
        rd_cnt  = DATA_LAT;
        rd_addr = mem_addr;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [DATA_W:0]   e;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rd: got addr %h expected no read", mem_addr);
        end else begin
          a = addr_q.pop_front();
          chk("rd_addr", mem_addr, a);
        end
      end
      if (ack0 || ack1) begin
        chk("ack_exclusive", {31'd0, ack0 & ack1}, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none", ack0, ack1);
        end else begin
          e = exp_q.pop_front();
          chk("ack_channel", {31'd0, ack1}, {31'd0, e[DATA_W]});
          chk("ack_data", ack1 ? data1 : data0, e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    int rd_snap;
    logic ch;
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    mem_ena   = 1'b1;
    mem_slot  = 1'b0;
    sel_drive = 1'b1;
    req0      = 1'b1;
    req1      = 1'b1;
    addr0     = 25'h000200;
    addr1     = 25'h123456;
    cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_data0", data0, 0);
    chk("rst_data1", data1, 0);
    reset_n = 1'b1;

    // T2 contention from reset: ch0 first, then alternate; mid-op slots ignored
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expect_rd(1'b0, 25'h000200, 16'hBDEF, 1'b1);
      else            expect_rd(1'b1, 25'h123456, 16'h8BB9, 1'b1);
      slot();
      chk("t2_rd", mem_rd, 1);
      slot();
      cycles(2);
      chk("t2_idle", busy, 0);
    end

    // T1 single request timing
    req1  = 1'b0;
    addr0 = 25'h000100;
    expect_rd(1'b0, 25'h000100, 16'hBEEF, 1'b1);
    slot();
    chk("t1_rd", mem_rd, 1);
    chk("t1_addr", mem_addr, 25'h000100);
    chk("t1_busy", busy, 1);
    addr0 = 25'h000999;
    cycles(1);
    chk("t1_rd_once", mem_rd, 0);
    cycles(2);
    chk("t1_ack0", ack0, 1);
    chk("t1_ack1", ack1, 0);
    chk("t1_data0", data0, 16'hBEEF);
    cycles(1);
    chk("t1_ack0_pulse", ack0, 0);
    req0 = 1'b0;

    // T3 disabled: no reads, then the next slot issues
    req1    = 1'b1;
    addr1   = 25'h000300;
    mem_ena = 1'b0;
    rd_snap = rd_total;
    repeat (10) slot();
    chk("t3_no_rd", rd_total, rd_snap);
    chk("t3_idle", busy, 0);
    mem_ena = 1'b1;
    expect_rd(1'b1, 25'h000300, 16'hBCEF, 1'b1);
    slot();
    chk("t3_rd", mem_rd, 1);
    cycles(4);
    chk("t3_data1", data1, 16'hBCEF);
    req1 = 1'b0;

    // T4 withdrawal after mem_rd: silent completion, data0 kept
    req0  = 1'b1;
    addr0 = 25'h000400;
    expect_rd(1'b0, 25'h000400, 16'h0, 1'b0);
    slot();
    cycles(1);
    req0 = 1'b0;
    cycles(2);
    chk("t4_resp_busy", busy, 1);
    chk("t4_no_ack", {ack1, ack0}, 0);
    cycles(1);
    chk("t4_idle", busy, 0);
    chk("t4_data0_kept", data0, 16'hBEEF);

    // T5 reset during WAIT, then ch0 wins first again
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 25'h000100;
    addr1 = 25'h123456;
    expect_rd(1'b1, 25'h123456, 16'h0, 1'b0);
    slot();
    cycles(1);
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_mem_rd", mem_rd, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_ack", {ack1, ack0}, 0);
    chk("t5_data0", data0, 0);
    chk("t5_data1", data1, 0);
    cycles(2);
    reset_n = 1'b1;
    expect_rd(1'b0, 25'h000100, 16'hBEEF, 1'b1);
    slot();
    chk("t5_first_ch0", mem_addr, 25'h000100);
    cycles(4);

    // T6 sel_drive=1 with both requesting
    for (int i = 0; i < 3; i++) begin
`ifdef MDV_ARB_SELPRIO_EN
      ch = 1'b1;
`else
      ch = (i % 2 == 0) ? 1'b1 : 1'b0;
`endif
      if (ch) expect_rd(1'b1, 25'h123456, 16'h8BB9, 1'b1);
      else    expect_rd(1'b0, 25'h000100, 16'hBEEF, 1'b1);
      slot();
      cycles(4);
    end

    req0 = 1'b0;
    req1 = 1'b0;
    cycles(6);
    chk("left_acks", exp_q.size(), 0);
    chk("left_reads", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
